// File: rtl/alu_seq_pkg.sv
// Shared widths, opcode names and the command/result record layouts for the
// ALU operand sequencer.
package alu_seq_pkg;
  localparam int DEF_DW = 16;
  localparam int DEF_SW = 3;

  localparam logic [DEF_SW-1:0] SEL_OP0 = 3'b000;
  localparam logic [DEF_SW-1:0] SEL_OP1 = 3'b001;
  localparam logic [DEF_SW-1:0] SEL_OP2 = 3'b010;
  localparam logic [DEF_SW-1:0] SEL_OP3 = 3'b011;
  localparam logic [DEF_SW-1:0] SEL_OP4 = 3'b100;
  localparam logic [DEF_SW-1:0] SEL_OP5 = 3'b101;
  localparam logic [DEF_SW-1:0] SEL_OP6 = 3'b110;
  localparam logic [DEF_SW-1:0] SEL_OP7 = 3'b111;

  typedef struct packed {
    logic [DEF_DW-1:0] a;
    logic [DEF_DW-1:0] b;
    logic [DEF_SW-1:0] sel;
  } cmd_t;

  typedef struct packed {
    logic [DEF_DW-1:0] q;
    logic [DEF_SW-1:0] sel;
  } res_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous reset; head reads as zero while empty.
// Push on a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// Feeds queued operand commands into a clocked ALU one per cycle and returns
// each q, tagged with its sel, in issue order through a result FIFO.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int SW      = DEF_SW,
  parameter int ALU_LAT = 1,
  parameter int CDEPTH  = 4,
  parameter int RDEPTH  = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [DW-1:0] cmd_a,
  input  logic [DW-1:0] cmd_b,
  input  logic [SW-1:0] cmd_sel,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [SW-1:0] alu_sel,
  input  logic [DW-1:0] alu_q,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_q,
  output logic [SW-1:0] res_sel,
  output logic          busy,
  output logic [15:0]   issue_cnt
);
  localparam int CW = 2*DW + SW;
  localparam int RW = DW + SW;

  logic [CW-1:0]               cmd_head;
  logic                        cmd_full, cmd_empty;
  logic [$clog2(CDEPTH):0]     cmd_count;
  logic [RW-1:0]               res_head;
  logic                        res_full, res_empty;
  logic [$clog2(RDEPTH):0]     res_count;
  logic                        issue, credit, res_pop;
  int                          inflight;
  logic                        unused_ok;

  // Stage 0 is the op sitting on alu_*; stage ALU_LAT is the one whose q is
  // on alu_q now, since the ALU registers its result ALU_LAT edges later.
  logic [ALU_LAT:0]            vld_pipe;
  logic [ALU_LAT:0][SW-1:0]    sel_pipe;

  assign cmd_ready = !cmd_full && !reset;

  sync_fifo #(.WIDTH(CW), .DEPTH(CDEPTH)) u_cmd_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_valid && cmd_ready),
    .din   ({cmd_a, cmd_b, cmd_sel}),
    .pop   (issue),
    .dout  (cmd_head),
    .full  (cmd_full),
    .empty (cmd_empty),
    .count (cmd_count)
  );

  // Every op in the pipe owns a result slot; a same-cycle pop is not counted
  // so res_ready has no combinational path into issue.
  assign inflight = $countones(vld_pipe);
  assign credit   = (int'(res_count) + inflight) < RDEPTH;
  assign issue    = !cmd_empty && credit;

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      vld_pipe  <= '0;
      sel_pipe  <= '0;
      issue_cnt <= '0;
    end else begin
      vld_pipe <= {vld_pipe[ALU_LAT-1:0], issue};
      sel_pipe <= {sel_pipe[ALU_LAT-1:0], cmd_head[SW-1:0]};
      if (issue) begin
        {alu_a, alu_b, alu_sel} <= cmd_head;
        issue_cnt               <= issue_cnt + 16'd1;
      end
    end
  end

  assign res_pop = !res_empty && res_ready;

  sync_fifo #(.WIDTH(RW), .DEPTH(RDEPTH)) u_res_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (vld_pipe[ALU_LAT]),
    .din   ({alu_q, sel_pipe[ALU_LAT]}),
    .pop   (res_pop),
    .dout  (res_head),
    .full  (res_full),
    .empty (res_empty),
    .count (res_count)
  );

  assign res_valid        = !res_empty;
  assign {res_q, res_sel} = res_head;
  assign busy             = !cmd_empty || (|vld_pipe) || !res_empty;

  assign unused_ok = &{1'b0, res_full, cmd_count};
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with a registered a+b stub ALU; a scoreboard
// queues expected results on command accept and checks them as they leave.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [15:0] cmd_a, cmd_b;
  logic [2:0]  cmd_sel;
  logic [15:0] alu_a, alu_b, alu_q;
  logic [2:0]  alu_sel;
  logic        res_valid, res_ready;
  logic [15:0] res_q;
  logic [2:0]  res_sel;
  logic        busy;
  logic [15:0] issue_cnt;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_pop   = 0;
  int          cyc     = 0;
  logic [15:0] exp_issue = 16'd0;
  logic [15:0] last_q;
  res_t        exp_q[$];
  int          pop_cyc[$];
  res_t        mon_e;
  logic [15:0] mon_sum;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) alu_q <= alu_a + alu_b;

  alu_op_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_sel   (cmd_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_q     (alu_q),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_q     (res_q),
    .res_sel   (res_sel),
    .busy      (busy),
    .issue_cnt (issue_cnt)
  );

  // Scoreboard: sampled mid-cycle, both transfers complete at the next edge.
  always @(negedge clk) begin
    if (cmd_valid && cmd_ready) begin
      mon_sum = cmd_a + cmd_b;
      mon_e.q = mon_sum;
      mon_e.sel = cmd_sel;
      exp_q.push_back(mon_e);
    end
    if (res_valid && res_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL res_unexpected: got q=%0d sel=%0d, required no result", res_q, res_sel);
      end else begin
        mon_e = exp_q.pop_front();
        if (res_q !== mon_e.q || res_sel !== mon_e.sel) begin
          n_fail++;
          $display("FAIL res_data: got q=%0d sel=%0d, required q=%0d sel=%0d",
                   res_q, res_sel, mon_e.q, mon_e.sel);
        end
      end
      n_pop++;
      pop_cyc.push_back(cyc);
      last_q = res_q;
    end
  end

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push_cmd(input logic [15:0] a, input logic [15:0] b, input logic [2:0] sel);
    int k = 0;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_sel = sel;
    @(negedge clk);
    while (!cmd_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) begin
      n_tests++; n_fail++;
      $display("FAIL push_timeout: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, k);
    end else begin
      exp_issue = exp_issue + 16'd1;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_pops(input int target, input int bound, output bit ok);
    int k = 0;
    while (n_pop < target && k < bound) begin
      @(posedge clk); #1;
      k++;
    end
    ok = (n_pop >= target);
  endtask

  task automatic test_reset;
    reset = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_sel = '0;
    @(negedge clk); @(negedge clk);
    n_tests++;
    if (cmd_ready !== 1'b0 || alu_a !== 16'd0 || alu_b !== 16'd0 || alu_sel !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_alu: got ready=%0b a=%0h b=%0h sel=%0h, required 0 0 0 0",
               cmd_ready, alu_a, alu_b, alu_sel);
    end
    n_tests++;
    if (res_valid !== 1'b0 || res_q !== 16'd0 || res_sel !== 3'd0 || busy !== 1'b0 || issue_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_res: got valid=%0b q=%0h sel=%0h busy=%0b cnt=%0h, required all 0",
               res_valid, res_q, res_sel, busy, issue_cnt);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got cmd_ready=%0b, required 1", cmd_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    int k = 0;
    push_cmd(16'd23, 16'd43, SEL_OP0);
    @(negedge clk); @(negedge clk);
    n_tests++;
    if (alu_a !== 16'd23 || alu_b !== 16'd43 || alu_sel !== SEL_OP0 || issue_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL single_issue: got a=%0d b=%0d sel=%0d cnt=%0d, required 23 43 0 1",
               alu_a, alu_b, alu_sel, issue_cnt);
    end
    while (!res_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (k !== 2) begin
      n_fail++;
      $display("FAIL single_latency: got %0d cycles after issue, required 2", k);
    end
    n_tests++;
    if (res_q !== 16'd66 || res_sel !== SEL_OP0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_head: got q=%0d sel=%0d busy=%0b, required 66 0 1", res_q, res_sel, busy);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || n_pop !== 1) begin
      n_fail++;
      $display("FAIL single_drain: got busy=%0b valid=%0b pops=%0d, required 0 0 1", busy, res_valid, n_pop);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_burst;
    logic [15:0] av [8] = '{16'd45, 16'd33, 16'd86, 16'd12, 16'd250, 16'd1000, 16'hFFFF, 16'd7};
    logic [15:0] bv [8] = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd1, 16'd9};
    int base = n_pop;
    bit ok;
    pop_cyc.delete();
    res_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_cmd(av[i], bv[i], 3'(i));
    wait_pops(base + 8, 50, ok);
    n_tests++;
    if (!ok || pop_cyc.size() != 8) begin
      n_fail++;
      $display("FAIL burst_count: got %0d results, required 8", n_pop - base);
    end else begin
      n_tests++;
      if (pop_cyc[7] - pop_cyc[0] != 7) begin
        n_fail++;
        $display("FAIL burst_gaps: got %0d cycles first..last, required 7", pop_cyc[7] - pop_cyc[0]);
      end
    end
    n_tests++;
    if (issue_cnt !== exp_issue || exp_issue !== 16'd9) begin
      n_fail++;
      $display("FAIL burst_issue_cnt: got %0d, required 9", issue_cnt);
    end
  endtask

  task automatic test_backpressure;
    int base = n_pop;
    bit ok;
    res_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_cmd(16'(100 + i), 16'(i * 3), 3'(7 - i));
    repeat (10) @(posedge clk);
    #1;
    @(negedge clk);
    n_tests++;
    if (res_valid !== 1'b1 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_stall: got valid=%0b cmd_ready=%0b busy=%0b, required 1 0 1", res_valid, cmd_ready, busy);
    end
    n_tests++;
    if (issue_cnt !== 16'd13 || n_pop !== base) begin
      n_fail++;
      $display("FAIL bp_held: got issue_cnt=%0d pops=%0d, required 13 %0d", issue_cnt, n_pop, base);
    end
    n_tests++;
    if (res_q !== 16'd100 || res_sel !== 3'd7) begin
      n_fail++;
      $display("FAIL bp_head: got q=%0d sel=%0d, required 100 7", res_q, res_sel);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    wait_pops(base + 8, 60, ok);
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (!ok || n_pop !== base + 8 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_drain: got %0d results, %0d outstanding, required 8 and 0", n_pop - base, exp_q.size());
    end
    n_tests++;
    if (issue_cnt !== 16'd17 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_final: got cnt=%0d ready=%0b busy=%0b, required 17 1 0", issue_cnt, cmd_ready, busy);
    end
  endtask

  task automatic test_reset_midflight;
    int base;
    bit ok;
    bit seen = 1'b0;
    res_ready = 1'b1;
    push_cmd(16'd1, 16'd2, SEL_OP1);
    push_cmd(16'd4, 16'd5, SEL_OP2);
    push_cmd(16'd8, 16'd9, SEL_OP3);
    // first op is inside the ALU now, second on alu_*, third queued
    reset = 1'b1;
    exp_q.delete();
    exp_issue = 16'd0;
    base = n_pop;
    @(negedge clk);
    n_tests++;
    if (cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_ready: got cmd_ready=%0b during reset, required 0", cmd_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (alu_a !== 16'd0 || alu_b !== 16'd0 || alu_sel !== 3'd0 || res_valid !== 1'b0 ||
        res_q !== 16'd0 || busy !== 1'b0 || issue_cnt !== 16'd0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_state: got a=%0h b=%0h sel=%0h valid=%0b q=%0h busy=%0b cnt=%0h ready=%0b, required 0s and ready=1",
               alu_a, alu_b, alu_sel, res_valid, res_q, busy, issue_cnt, cmd_ready);
    end
    repeat (6) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    n_tests++;
    if (seen || n_pop !== base) begin
      n_fail++;
      $display("FAIL rst_discard: got res_valid seen=%0b pops=%0d, required 0 %0d", seen, n_pop, base);
    end
    @(posedge clk); #1;
    push_cmd(16'd3, 16'd7, SEL_OP5);
    wait_pops(base + 1, 20, ok);
    n_tests++;
    if (!ok || last_q !== 16'd10 || issue_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL rst_new_op: got q=%0d cnt=%0d, required 10 1", last_q, issue_cnt);
    end
  endtask

  task automatic test_wrap;
    int k = 0;
    res_ready = 1'b1;
    while (exp_issue != 16'hFFFF) begin
      push_cmd(exp_issue, ~exp_issue, exp_issue[2:0]);
    end
    while ((exp_q.size() != 0 || busy) && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    n_tests++;
    if (issue_cnt !== 16'hFFFF || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL wrap_max: got cnt=%0h outstanding=%0d, required ffff 0", issue_cnt, exp_q.size());
    end
    push_cmd(16'h1234, 16'h4321, SEL_OP6);
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    n_tests++;
    if (issue_cnt !== 16'h0000 || last_q !== 16'h5555) begin
      n_fail++;
      $display("FAIL wrap_zero: got cnt=%0h q=%0h, required 0 5555", issue_cnt, last_q);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_burst;
    test_backpressure;
    test_reset_midflight;
    test_wrap;
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
